vmicro16_bram_excl_apb: RTL and testbench
=========================================

VMICRO16_BRAM_EXCL_APB -- requirements
Module: vmicro16_bram_excl_apb

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 20: APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: memory word and APB data width.
REQ-003 SHALL have parameter MEM_DEPTH, default 64: number of words, a power of two.
REQ-004 SHALL have parameter CORES, default 4: number of reservation monitors.
REQ-005 SHALL have parameter CORE_ID_BITS, default 2: width of the core-ID field in S_PADDR.
REQ-006 SHALL have parameter SWEX_SUCCESS, default 16'h0000: PRDATA value for a successful SWEX.
REQ-007 SHALL have parameter SWEX_FAIL, default 16'h0001: PRDATA value for a failed SWEX.
REQ-008 SHALL have parameter TIMEOUT_CYCLES, default 255: reservation lifetime in cycles, 1..65535.
REQ-009 SHALL have port clk, input, 1: clock; one clock, all logic on its rising edge.
REQ-010 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-011 SHALL have ports S_PADDR (input, BUS_WIDTH), S_PWRITE (input, 1), S_PSELx (input, 1), S_PENABLE (input, 1) and S_PWDATA (input, DATA_WIDTH): APB slave request.
REQ-012 SHALL have ports S_PRDATA (output, DATA_WIDTH, registered) and S_PREADY (output, 1, registered): APB slave response.
REQ-013 SHALL have port o_resv_valid, output, CORES: per-core reservation-valid flags.
REQ-014 SHALL have port o_swex_fail_cnt, output, 16: saturating count of failed SWEX transfers.

Function
REQ-015 SHALL decode S_PADDR as follows: bit BUS_WIDTH-1 = LWEX; bit BUS_WIDTH-2 = SWEX; the next CORE_ID_BITS bits below = core_id; the low clog2(MEM_DEPTH) bits = word index; all other bits ignored.
REQ-016 SHALL implement a two-state FSM. IDLE -> RESP when S_PSELx&S_PENABLE in IDLE. RESP -> IDLE unconditionally.
REQ-017 SHALL assert S_PREADY only in RESP, giving exactly one wait state per transfer.
REQ-018 SHALL commit all side effects (memory write, reservation update, counter update) on the IDLE->RESP edge, evaluated against the state held before that edge.
REQ-019 SHALL, for a plain read, return mem[index] and leave reservations unchanged.
REQ-020 SHALL, for LWEX with S_PWRITE=0, return mem[index], set the reservation of core_id to {valid, index} replacing any previous one, and load that core's timer with TIMEOUT_CYCLES.
REQ-021 SHALL treat SWEX as successful iff the reservation of core_id is valid and its address equals index.
REQ-022 SHALL, on a successful SWEX, write S_PWDATA to memory, return SWEX_SUCCESS, and clear every core's reservation whose address equals index.
REQ-023 SHALL, on a failed SWEX, leave memory unchanged, return SWEX_FAIL, clear core_id's reservation, and increment o_swex_fail_cnt, saturating at 16'hFFFF.
REQ-024 SHALL, on a plain write, write memory, clear every reservation matching index, and return 0.
REQ-025 SHALL treat core_id >= CORES as follows: LWEX behaves as a plain read; SWEX fails.
REQ-026 SHALL handle LWEX and SWEX both set as SWEX.
REQ-027 SHALL handle a deassertion of S_PSELx during RESP as follows: return to IDLE; committed side effects persist.

Reset
REQ-028 SHALL, on reset, force the FSM to IDLE, S_PREADY=0, S_PRDATA=0, o_resv_valid=0, o_swex_fail_cnt=0, and all timers to 0.
REQ-029 SHALL preserve memory contents across reset.
REQ-030 SHALL abandon a transfer in progress when reset is asserted.

Configuration
REQ-031 SHALL use macro VMICRO16_BRAM_EX_TIMEOUT_EN to control reservation timeout. When defined, each valid timer decrements every cycle and the reservation clears on the edge where the timer goes 1->0, giving a lifetime of exactly TIMEOUT_CYCLES cycles. A SWEX committing on that same edge sees the reservation as valid. When not defined, there are no timers and reservations never expire.

Verification
REQ-032 SHALL verify this scenario: core 1 does LWEX at 0x05, then SWEX at 0x05 with data 0xBEEF -> PRDATA=0x0000, mem[5]=0xBEEF, o_resv_valid[1]=0.
REQ-033 SHALL verify this scenario: cores 0 and 2 both LWEX at 0x05, then core 2 SWEX succeeds, then core 0 SWEX -> PRDATA=0x0001, mem[5] unchanged by core 0, o_swex_fail_cnt=1.
REQ-034 SHALL verify this scenario: core 3 LWEX at 0x10, then core 0 plain-writes 0x10, then core 3 SWEX -> fail, o_resv_valid[3]=0.
REQ-035 SHALL verify this scenario: with TIMEOUT_EN defined and TIMEOUT_CYCLES=8, LWEX, then SWEX committing 8 cycles later -> success; the same sequence at 9 cycles -> fail.
REQ-036 SHALL verify this scenario: every transfer -> S_PREADY high exactly one cycle after PENABLE is first seen high, then low.
REQ-037 SHALL verify this scenario: reset asserted in RESP -> S_PREADY=0 immediately, o_resv_valid=0, and mem retains the written values.

Source files
------------

// File: rtl/vmicro16_bram_excl_apb.sv
// APB word memory with per-core LWEX/SWEX reservation monitors; `VMICRO16_BRAM_EX_TIMEOUT_EN adds reservation expiry.
// One wait state per transfer (S_PREADY registered high for one cycle); no further backpressure.
module vmicro16_bram_excl_apb #(
   parameter int                    BUS_WIDTH      = 20,
   parameter int                    DATA_WIDTH     = 16,
   parameter int                    MEM_DEPTH      = 64,
   parameter int                    CORES          = 4,
   parameter int                    CORE_ID_BITS   = 2,
   parameter logic [DATA_WIDTH-1:0] SWEX_SUCCESS   = 16'h0000,
   parameter logic [DATA_WIDTH-1:0] SWEX_FAIL      = 16'h0001,
   parameter int                    TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BUS_WIDTH-1:0]  S_PADDR,
   input  logic                  S_PWRITE,
   input  logic                  S_PSELx,
   input  logic                  S_PENABLE,
   input  logic [DATA_WIDTH-1:0] S_PWDATA,
   output logic [DATA_WIDTH-1:0] S_PRDATA,
   output logic                  S_PREADY,
   output logic [CORES-1:0]      o_resv_valid,
   output logic [15:0]           o_swex_fail_cnt
);
   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic {ST_IDLE, ST_RESP} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic                    pready_q, pready_d;
   logic [CORES-1:0]        valid_q, valid_d;
   logic [AW-1:0]           addr_q [CORES];
   logic [AW-1:0]           addr_d [CORES];
   logic [15:0]             cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
   logic                    mem_we;
`ifdef VMICRO16_BRAM_EX_TIMEOUT_EN
   logic [15:0]             timer_q [CORES];
   logic [15:0]             timer_d [CORES];
`endif

   logic                    lwex, swex, core_ok, swex_ok;
   logic [CORE_ID_BITS-1:0] core_id;
   logic [AW-1:0]           idx;
   logic                    unused_paddr;

   assign lwex         = S_PADDR[BUS_WIDTH-1];
   assign swex         = S_PADDR[BUS_WIDTH-2];
   assign core_id      = S_PADDR[BUS_WIDTH-3 -: CORE_ID_BITS];
   assign idx          = S_PADDR[AW-1:0];
   assign unused_paddr = ^S_PADDR;
   assign core_ok      = int'(core_id) < CORES;
   // Success is judged on pre-edge state, so an expiring reservation still counts.
   assign swex_ok      = core_ok && valid_q[core_id] && (addr_q[core_id] == idx);

   always_comb begin
      state_d  = state_q;
      prdata_d = prdata_q;
      pready_d = 1'b0;
      valid_d  = valid_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      mem_we   = 1'b0;
`ifdef VMICRO16_BRAM_EX_TIMEOUT_EN
      timer_d  = timer_q;
      for (int c = 0; c < CORES; c++) begin
         if (valid_q[c] && timer_q[c] != 16'd0) begin
            timer_d[c] = timer_q[c] - 16'd1;
            if (timer_q[c] == 16'd1) valid_d[c] = 1'b0;
         end
      end
`endif
      case (state_q)
         ST_IDLE: begin
            if (S_PSELx && S_PENABLE) begin
               state_d  = ST_RESP;
               pready_d = 1'b1;
               if (swex) begin
                  if (swex_ok) begin
                     mem_we   = 1'b1;
                     prdata_d = SWEX_SUCCESS;
                     for (int c = 0; c < CORES; c++)
                        if (addr_q[c] == idx) valid_d[c] = 1'b0;
                  end else begin
                     prdata_d = SWEX_FAIL;
                     if (core_ok) valid_d[core_id] = 1'b0;
                     if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                  end
               end else if (S_PWRITE) begin
                  mem_we   = 1'b1;
                  prdata_d = '0;
                  for (int c = 0; c < CORES; c++)
                     if (addr_q[c] == idx) valid_d[c] = 1'b0;
               end else begin
                  prdata_d = mem_q[idx];
                  if (lwex && core_ok) begin
                     valid_d[core_id] = 1'b1;
                     addr_d[core_id]  = idx;
`ifdef VMICRO16_BRAM_EX_TIMEOUT_EN
                     timer_d[core_id] = 16'(TIMEOUT_CYCLES);
`endif
                  end
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         prdata_q <= '0;
         pready_q <= 1'b0;
         valid_q  <= '0;
         cnt_q    <= '0;
         for (int c = 0; c < CORES; c++) begin
            addr_q[c]  <= '0;
`ifdef VMICRO16_BRAM_EX_TIMEOUT_EN
            timer_q[c] <= '0;
`endif
         end
      end else begin
         state_q  <= state_d;
         prdata_q <= prdata_d;
         pready_q <= pready_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
`ifdef VMICRO16_BRAM_EX_TIMEOUT_EN
         timer_q  <= timer_d;
`endif
      end
   end

   // Storage has no reset so contents survive it.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem_q[idx] <= S_PWDATA;
   end

   assign S_PRDATA        = prdata_q;
   assign S_PREADY        = pready_q;
   assign o_resv_valid    = valid_q;
   assign o_swex_fail_cnt = cnt_q;
endmodule

// File: tb/tb_vmicro16_bram_excl_apb.sv
// Bench for vmicro16_bram_excl_apb: directed scenarios plus random traffic against a timestamp-based reservation model.
module tb_vmicro16_bram_excl_apb;
   localparam int T = 8;
`ifdef VMICRO16_BRAM_EX_TIMEOUT_EN
   localparam bit TO = 1'b1;
`else
   localparam bit TO = 1'b0;
`endif

   logic        clk, reset;
   logic [19:0] S_PADDR;
   logic        S_PWRITE, S_PSELx, S_PENABLE;
   logic [15:0] S_PWDATA, S_PRDATA;
   logic        S_PREADY;
   logic [3:0]  o_resv_valid;
   logic [15:0] o_swex_fail_cnt;

   vmicro16_bram_excl_apb #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
      .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
      .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
      .o_resv_valid(o_resv_valid), .o_swex_fail_cnt(o_swex_fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   // Reference state: memory image, reservations stamped with the edge they were taken on.
   logic [15:0] mem_m [64];
   bit          rv [4];
   int          ra [4];
   int          re [4];
   int          fcnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] resv_exp(input int now);
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = rv[c] && (!TO || (now - re[c]) < T);
      return v;
   endfunction

   task automatic apb(input bit lw, input bit sw, input int core, input int idx, input bit wr,
                      input logic [15:0] wd, input int idle, input bit rst_in_resp,
                      output logic [15:0] rd);
      logic [15:0] exp_rd;
      bit ok;
      int e;
      repeat (idle) @(posedge clk);
      @(posedge clk); #1;
      S_PADDR   = 20'(idx) | (20'($urandom_range(0, 1023)) << 6) | (20'(core) << 16)
                | (sw ? 20'h40000 : 20'h0) | (lw ? 20'h80000 : 20'h0);
      S_PWRITE  = wr;
      S_PWDATA  = wd;
      S_PSELx   = 1'b1;
      S_PENABLE = 1'b0;
      @(posedge clk); #1;
      chk("pready_setup", 32'(S_PREADY), 32'd0);
      S_PENABLE = 1'b1;
      @(posedge clk); #1;
      e = cyc;
      chk("pready_resp", 32'(S_PREADY), 32'd1);
      if (sw) begin
         ok = rv[core] && ra[core] == idx && (!TO || (e - re[core]) <= T);
         if (ok) begin
            mem_m[idx] = wd;
            exp_rd = 16'h0000;
            for (int c = 0; c < 4; c++) if (ra[c] == idx) rv[c] = 1'b0;
         end else begin
            exp_rd = 16'h0001;
            rv[core] = 1'b0;
            if (fcnt < 65535) fcnt++;
         end
      end else if (wr) begin
         mem_m[idx] = wd;
         exp_rd = 16'h0000;
         for (int c = 0; c < 4; c++) if (ra[c] == idx) rv[c] = 1'b0;
      end else begin
         exp_rd = mem_m[idx];
         if (lw) begin rv[core] = 1'b1; ra[core] = idx; re[core] = e; end
      end
      chk("prdata", 32'(S_PRDATA), 32'(exp_rd));
      rd = S_PRDATA;
      if (rst_in_resp) begin
         reset = 1'b1;
         #1;
         chk("rst_pready", 32'(S_PREADY), 32'd0);
         chk("rst_prdata", 32'(S_PRDATA), 32'd0);
         chk("rst_resv", 32'(o_resv_valid), 32'd0);
         chk("rst_cnt", 32'(o_swex_fail_cnt), 32'd0);
         for (int c = 0; c < 4; c++) rv[c] = 1'b0;
         fcnt = 0;
         S_PSELx = 1'b0; S_PENABLE = 1'b0;
         @(posedge clk); #1;
         reset = 1'b0;
         chk("rst_hold_pready", 32'(S_PREADY), 32'd0);
      end else begin
         @(posedge clk); #1;
         S_PSELx = 1'b0; S_PENABLE = 1'b0;
         chk("pready_done", 32'(S_PREADY), 32'd0);
         chk("resv_valid", 32'(o_resv_valid), 32'(resv_exp(cyc)));
         chk("fail_cnt", 32'(o_swex_fail_cnt), 32'(fcnt));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [15:0] rd;
      int op, core, idx;
      reset = 1'b1; S_PADDR = '0; S_PWRITE = 1'b0; S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWDATA = '0;
      for (int c = 0; c < 4; c++) begin rv[c] = 1'b0; ra[c] = 0; re[c] = 0; end
      repeat (3) @(posedge clk); #1;
      chk("reset_pready", 32'(S_PREADY), 32'd0);
      chk("reset_prdata", 32'(S_PRDATA), 32'd0);
      chk("reset_resv", 32'(o_resv_valid), 32'd0);
      chk("reset_cnt", 32'(o_swex_fail_cnt), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 64; i++) apb(0, 0, i % 4, i, 1, 16'($urandom), 0, 0, rd);

      // Simple LWEX/SWEX pair
      apb(1, 0, 1, 5, 0, 16'h0, 0, 0, rd);
      chk("s1_resv_set", 32'(o_resv_valid[1]), 32'd1);
      apb(0, 1, 1, 5, 1, 16'hBEEF, 0, 0, rd);
      chk("s1_swex_rd", 32'(rd), 32'h0000);
      chk("s1_resv_clr", 32'(o_resv_valid[1]), 32'd0);
      apb(0, 0, 0, 5, 0, 16'h0, 0, 0, rd);
      chk("s1_mem", 32'(rd), 32'hBEEF);

      // Two cores contend for the same word
      apb(1, 0, 0, 5, 0, 16'h0, 0, 0, rd);
      apb(1, 0, 2, 5, 0, 16'h0, 0, 0, rd);
      apb(0, 1, 2, 5, 1, 16'h1234, 0, 0, rd);
      chk("s2_core2_rd", 32'(rd), 32'h0000);
      apb(0, 1, 0, 5, 1, 16'h5555, 0, 0, rd);
      chk("s2_core0_rd", 32'(rd), 32'h0001);
      chk("s2_cnt", 32'(o_swex_fail_cnt), 32'd1);
      apb(0, 0, 0, 5, 0, 16'h0, 0, 0, rd);
      chk("s2_mem", 32'(rd), 32'h1234);

      // Plain write steals a reservation
      apb(1, 0, 3, 16, 0, 16'h0, 0, 0, rd);
      apb(0, 0, 0, 16, 1, 16'hABCD, 0, 0, rd);
      chk("s3_resv_after_wr", 32'(o_resv_valid[3]), 32'd0);
      apb(0, 1, 3, 16, 1, 16'h7777, 0, 0, rd);
      chk("s3_swex_rd", 32'(rd), 32'h0001);
      chk("s3_resv", 32'(o_resv_valid[3]), 32'd0);
      apb(0, 0, 1, 16, 0, 16'h0, 0, 0, rd);
      chk("s3_mem", 32'(rd), 32'hABCD);

      // SWEX exactly at and one past the reservation lifetime
      apb(1, 0, 1, 7, 0, 16'h0, 0, 0, rd);
      apb(0, 1, 1, 7, 1, 16'h0808, 4, 0, rd);
      chk("to_at_T", 32'(rd), 32'h0000);
      apb(1, 0, 1, 7, 0, 16'h0, 0, 0, rd);
      apb(0, 1, 1, 7, 1, 16'h0909, 5, 0, rd);
      chk("to_past_T", 32'(rd), TO ? 32'h0001 : 32'h0000);

      // Long idle with a live reservation
      apb(1, 0, 2, 20, 0, 16'h0, 0, 0, rd);
      repeat (300) @(posedge clk); #1;
      chk("long_idle_resv2", 32'(o_resv_valid[2]), TO ? 32'd0 : 32'd1);
      chk("long_idle_model", 32'(o_resv_valid), 32'(resv_exp(cyc)));

      for (int n = 0; n < 150; n++) begin
         op   = $urandom_range(0, 4);
         core = $urandom_range(0, 3);
         idx  = $urandom_range(0, 3);
         case (op)
            0: apb(0, 0, core, idx, 0, 16'h0, $urandom_range(0, 3), 0, rd);
            1: apb(0, 0, core, idx, 1, 16'($urandom), $urandom_range(0, 3), 0, rd);
            2: apb(1, 0, core, idx, 0, 16'h0, $urandom_range(0, 3), 0, rd);
            3: apb(0, 1, core, idx, 1, 16'($urandom), $urandom_range(0, 3), 0, rd);
            default: apb(1, 1, core, idx, 1, 16'($urandom), $urandom_range(0, 3), 0, rd);
         endcase
      end

      // Reset while the response is on the bus
      apb(1, 0, 0, 9, 0, 16'h0, 0, 0, rd);
      apb(0, 0, 1, 9, 1, 16'hC0DE, 0, 1, rd);
      apb(0, 0, 2, 9, 0, 16'h0, 0, 0, rd);
      chk("rst_mem9", 32'(rd), 32'hC0DE);
      apb(0, 0, 2, 5, 0, 16'h0, 0, 0, rd);
      apb(0, 0, 2, 16, 0, 16'h0, 0, 0, rd);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
